// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO controller in front of a 1-cycle-latency dual-port RAM; a
// two-entry head/skid output buffer hides the RAM read latency.
module bram_fifo_ctrl #(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [RAM_DATA_WIDTH-1:0] wr_data,
  output logic                      full,
  output logic                      rd_valid,
  output logic [RAM_DATA_WIDTH-1:0] rd_data,
  input  logic                      rd_pop,
  output logic [RAM_ADDR_WIDTH+1:0] count,
  output logic                      wr_err,
  output logic                      rd_err,
  output logic                      ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_wr_data,
  output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [RAM_DATA_WIDTH-1:0] ram_rd_data
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int DW = RAM_DATA_WIDTH;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   mem_cnt_r, mem_cnt_n_s;
  logic [AW+1:0] count_r, count_n_s;
  logic          inflight_r;
  logic          head_v_r, skid_v_r, head_v_n_s, skid_v_n_s;
  logic [DW-1:0] head_r, skid_r, head_n_s, skid_n_s;
  logic          wr_err_r, rd_err_r;
  logic          full_s, push_s, pop_s, issue_s, wr_err_s, rd_err_s;
  logic [1:0]    occ_s;

  assign full_s = (mem_cnt_r == DEPTH_C);

  // Accept/pop/prefetch decisions; mem_cnt excludes this cycle's write so a read never hits the write address.
  always_comb begin
    push_s   = 1'b0;
    pop_s    = 1'b0;
    issue_s  = 1'b0;
    wr_err_s = 1'b0;
    rd_err_s = 1'b0;
    occ_s    = 2'd0;
    if (!clr) begin
      push_s   = wr_en && !full_s && rst_n;
      pop_s    = rd_pop && head_v_r;
      wr_err_s = wr_en && full_s;
      rd_err_s = rd_pop && !head_v_r;
      occ_s    = {1'b0, head_v_r} + {1'b0, skid_v_r} + {1'b0, inflight_r} - {1'b0, pop_s};
      issue_s  = (mem_cnt_r != {(AW+1){1'b0}}) && (occ_s < 2'd2);
    end else begin
      push_s = 1'b0;
    end
  end

  // Output buffer next state: captured RAM data fills head first, else skid; a pop shifts skid into head.
  always_comb begin
    head_v_n_s = head_v_r;
    skid_v_n_s = skid_v_r;
    head_n_s   = head_r;
    skid_n_s   = skid_r;
    case ({pop_s, inflight_r})
      2'b11: begin
        if (skid_v_r) begin
          head_n_s = skid_r;
          skid_n_s = ram_rd_data;
        end else begin
          head_n_s = ram_rd_data;
        end
      end
      2'b10: begin
        if (skid_v_r) begin
          head_n_s = skid_r;
        end else begin
          head_n_s = head_r;
        end
        head_v_n_s = skid_v_r;
        skid_v_n_s = 1'b0;
      end
      2'b01: begin
        if (!head_v_r) begin
          head_n_s   = ram_rd_data;
          head_v_n_s = 1'b1;
        end else begin
          skid_n_s   = ram_rd_data;
          skid_v_n_s = 1'b1;
        end
      end
      default: begin
        head_v_n_s = head_v_r;
      end
    endcase
  end

  assign mem_cnt_n_s = mem_cnt_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, issue_s};
  assign count_n_s   = count_r + {{(AW+1){1'b0}}, push_s} - {{(AW+1){1'b0}}, pop_s};

  // State registers; clr flushes everything except the last presented rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      mem_cnt_r  <= {(AW+1){1'b0}};
      count_r    <= {(AW+2){1'b0}};
      inflight_r <= 1'b0;
      head_v_r   <= 1'b0;
      skid_v_r   <= 1'b0;
      head_r     <= {DW{1'b0}};
      skid_r     <= {DW{1'b0}};
      wr_err_r   <= 1'b0;
      rd_err_r   <= 1'b0;
    end else if (clr) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      mem_cnt_r  <= {(AW+1){1'b0}};
      count_r    <= {(AW+2){1'b0}};
      inflight_r <= 1'b0;
      head_v_r   <= 1'b0;
      skid_v_r   <= 1'b0;
      wr_err_r   <= 1'b0;
      rd_err_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (issue_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      mem_cnt_r  <= mem_cnt_n_s;
      count_r    <= count_n_s;
      inflight_r <= issue_s;
      head_v_r   <= head_v_n_s;
      skid_v_r   <= skid_v_n_s;
      head_r     <= head_n_s;
      skid_r     <= skid_n_s;
      wr_err_r   <= wr_err_s;
      rd_err_r   <= rd_err_s;
    end
  end

  assign full        = full_s;
  assign rd_valid    = head_v_r;
  assign rd_data     = head_r;
  assign count       = count_r;
  assign wr_err      = wr_err_r;
  assign rd_err      = rd_err_r;
  assign ram_wr      = push_s;
  assign ram_wr_addr = wr_ptr_r;
  assign ram_wr_data = wr_data;
  assign ram_rd_addr = rd_ptr_r;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl: directed table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_bram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CAP = 18;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_pop = 1'b0;
  logic [DW-1:0] wr_data = 8'h00;
  logic full, rd_valid, wr_err, rd_err, ram_wr;
  logic [DW-1:0] rd_data, ram_wr_data, ram_rd_data;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  bram_fifo_ctrl #(.RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .rd_valid(rd_valid), .rd_data(rd_data), .rd_pop(rd_pop),
    .count(count), .wr_err(wr_err), .rd_err(rd_err), .ram_wr(ram_wr),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Read-before-write synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_wr) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  typedef struct {
    logic wr, pop, cl;
    logic [7:0] din;
    logic v;
    logic [7:0] d;
    logic [5:0] cnt;
    logic fu, werr, rerr;
  } vec_t;

  vec_t tbl[14];
  logic [7:0] q[$];

  initial begin
    int exp_d;
    int gap;
    int wp, pp;
    logic was_full, exp_werr, exp_rerr;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 8'h00, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h11, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h11, 6'd0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 8'h11, 6'd1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 8'h22, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 8'h33, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33, 6'd0, 1'b0, 1'b0, 1'b0};

    // reset state
    #2;
    chk("rst_full", full, 0);      chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);   chk("rst_count", count, 0);
    chk("rst_werr", wr_err, 0);    chk("rst_rerr", rd_err, 0);
    chk("rst_ramwr", ram_wr, 0);   chk("rst_wraddr", ram_wr_addr, 0);
    chk("rst_rdaddr", ram_rd_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // directed table
    for (int i = 0; i < 14; i++) begin
      wr_en = tbl[i].wr; rd_pop = tbl[i].pop; clr = tbl[i].cl; wr_data = tbl[i].din;
      tick();
      wr_en = 1'b0; rd_pop = 1'b0; clr = 1'b0;
      chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].v);
      chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].fu);
      chk($sformatf("tbl%0d_werr", i), wr_err, tbl[i].werr);
      chk($sformatf("tbl%0d_rerr", i), rd_err, tbl[i].rerr);
    end

    // fill to capacity, overflow, push+pop while full, then drain
    for (int i = 0; i < CAP; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_full", full, (i == CAP - 1));
    end
    wr_data = 8'h12;
    tick();
    chk("ovf_werr", wr_err, 1); chk("ovf_count", count, CAP);
    wr_data = 8'h77; rd_pop = 1'b1;
    tick();
    wr_en = 1'b0; rd_pop = 1'b0;
    chk("fullpop_werr", wr_err, 1); chk("fullpop_count", count, CAP - 1);
    tick();
    chk("werr_pulse_end", wr_err, 0);
    exp_d = 1;
    for (int c = 0; c < 80 && exp_d < CAP; c++) begin
      if (rd_valid) begin
        chk("drain_data", rd_data, exp_d);
        exp_d++;
        rd_pop = 1'b1;
      end else begin
        rd_pop = 1'b0;
      end
      tick();
    end
    rd_pop = 1'b0;
    chk("drain_done", exp_d, CAP);
    chk("drain_valid", rd_valid, 0); chk("drain_count", count, 0);

    // prime 3 words then stream push+pop for 40 cycles
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick(); tick();
    chk("prime_count", count, 3); chk("prime_valid", rd_valid, 1);
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_pop = 1'b1; wr_data = 8'h43 + 8'(k);
      chk("stream_valid", rd_valid, 1);
      chk("stream_data", rd_data, 8'h40 + 8'(k));
      tick();
      chk("stream_count", count, 3);
    end
    wr_en = 1'b0; rd_pop = 1'b0;
    pulse_clr();

    // clr with a read in flight
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0; rd_pop = 1'b1;
    tick();
    clr = 1'b1; wr_en = 1'b1; rd_pop = 1'b1; wr_data = 8'h99;
    tick();
    clr = 1'b0; wr_en = 1'b0; rd_pop = 1'b0;
    chk("clr_valid", rd_valid, 0); chk("clr_count", count, 0);
    chk("clr_werr", wr_err, 0);    chk("clr_rerr", rd_err, 0);
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    for (int c = 0; c < 6 && !rd_valid; c++) tick();
    chk("clr_next_valid", rd_valid, 1); chk("clr_next_data", rd_data, 8'hA5);
    chk("clr_next_count", count, 1);
    pulse_clr();

    // asynchronous reset mid-operation
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_count", count, 7);
    @(posedge clk);
    #2 wr_en = 1'b1; wr_data = 8'h55;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0); chk("arst_count", count, 0);
    chk("arst_full", full, 0);      chk("arst_ramwr", ram_wr, 0);
    wr_en = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    chk("arst_lat_e1", rd_valid, 0);
    tick();
    chk("arst_lat_valid", rd_valid, 1); chk("arst_lat_data", rd_data, 8'h3C);

    // random traffic against the queue model
    pulse_clr();
    q.delete();
    exp_werr = 1'b0; exp_rerr = 1'b0; gap = 0;
    for (int i = 0; i < 800; i++) begin
      wp = (i < 200) ? 80 : (i < 400) ? 50 : (i < 600) ? 30 : 90;
      pp = (i < 200) ? 30 : (i < 400) ? 50 : (i < 600) ? 80 : 90;
      wr_en   = ($urandom_range(0, 99) < wp);
      rd_pop  = ($urandom_range(0, 99) < pp);
      clr     = ($urandom_range(0, 199) == 0);
      wr_data = 8'($urandom);
      chk("rnd_count", count, q.size());
      chk("rnd_full", full, (q.size() == CAP));
      chk("rnd_werr", wr_err, exp_werr);
      chk("rnd_rerr", rd_err, exp_rerr);
      if (rd_valid) begin
        chk("rnd_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) chk("rnd_data", rd_data, q[0]);
      end
      if (q.size() != 0 && !rd_valid) gap++;
      else gap = 0;
      if (q.size() != 0) chk("rnd_liveness", (gap <= 2), 1);
      if (clr) begin
        q.delete();
        exp_werr = 1'b0; exp_rerr = 1'b0;
      end else begin
        was_full = (q.size() == CAP);
        exp_werr = wr_en && was_full;
        exp_rerr = rd_pop && !rd_valid;
        if (rd_pop && rd_valid && q.size() != 0) void'(q.pop_front());
        if (wr_en && !was_full) q.push_back(wr_data);
      end
      tick();
    end
    wr_en = 1'b0; rd_pop = 1'b0; clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
